// File: rtl/polar_pkg.sv
// ---------------------------------------------------------------------------
// polar_pkg
// Shared types and constants for the polar-to-cartesian point engine.
//   state_t          : engine sequencing states
//   fold_t           : quarter-wave ROM address plus sign after quadrant fold
//   fold_quadrant()  : maps a full-circle angle onto the quarter-wave table
//   sine_entry()     : elaboration-time generator for one quarter-wave entry
//   build_sine_table(): packs all Q+1 entries into one constant vector
// ---------------------------------------------------------------------------
package polar_pkg;

    // Angle resolution: a full circle is 2^ANG_W steps.
    localparam int ANG_W   = 32'sd9;
    // Fraction bits of the sine table; entry Q equals 2^FRAC_W exactly.
    localparam int FRAC_W  = 32'sd10;
    // Steps per quadrant.
    localparam int Q       = 32'sd1 <<< (ANG_W - 32'sd2);
    // One extra bit so that the full-scale entry 2^FRAC_W is representable.
    localparam int ROM_W   = FRAC_W + 32'sd1;
    // Table address width; depth is Q+1 so entry Q needs the extra bit.
    localparam int ROM_A_W = ANG_W - 32'sd1;

    // Fixed-point format used only while generating the table: pi * 2^28.
    localparam int     FP_SH = 32'sd28;
    localparam longint PI_FP = 64'sd843314857;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COS_ADDR = 3'd1,
        SIN_ADDR = 3'd2,
        SIN_CAP  = 3'd3,
        CALC     = 3'd4
    } state_t;

    typedef struct packed {
        logic               neg;
        logic [ROM_A_W-1:0] addr;
    } fold_t;

    // Quadrant fold: q0 +T[i], q1 +T[Q-i], q2 -T[i], q3 -T[Q-i].
    function automatic fold_t fold_quadrant(input logic [ANG_W-1:0] ang);
        fold_t              f;
        logic [ROM_A_W-1:0] idx;
        idx = {1'b0, ang[ANG_W-3:0]};
        case (ang[ANG_W-1:ANG_W-2])
            2'd0: begin
                f.neg  = 1'b0;
                f.addr = idx;
            end
            2'd1: begin
                f.neg  = 1'b0;
                f.addr = ROM_A_W'(Q) - idx;
            end
            2'd2: begin
                f.neg  = 1'b1;
                f.addr = idx;
            end
            2'd3: begin
                f.neg  = 1'b1;
                f.addr = ROM_A_W'(Q) - idx;
            end
            default: begin
                f.neg  = 1'b0;
                f.addr = idx;
            end
        endcase
        return f;
    endfunction

    // round(2^FRAC_W * sin(k*pi/(2Q))) evaluated with an integer Taylor
    // series so the table is a pure constant at elaboration.
    function automatic logic [ROM_W-1:0] sine_entry(input int k);
        longint           x;
        longint           x2;
        longint           term;
        longint           acc;
        logic [ROM_W-1:0] res;
        if (k >= Q) begin
            res = ROM_W'(64'sd1 <<< FRAC_W);
        end else begin
            x    = (longint'(k) * PI_FP) / longint'(32'sd2 * Q);
            x2   = (x * x) >>> FP_SH;
            term = x;
            acc  = x;
            for (int n = 32'sd1; n <= 32'sd8; n++) begin
                term = -(((term * x2) >>> FP_SH) /
                         longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1)));
                acc  = acc + term;
            end
            res = ROM_W'((acc + (64'sd1 <<< (FP_SH - FRAC_W - 32'sd1))) >>> (FP_SH - FRAC_W));
        end
        return res;
    endfunction

    // Entry k lives at bits [k*ROM_W +: ROM_W].
    function automatic logic [(Q+1)*ROM_W-1:0] build_sine_table();
        logic [(Q+1)*ROM_W-1:0] t;
        t = '0;
        for (int k = 32'sd0; k <= Q; k++) begin
            t[k*ROM_W +: ROM_W] = sine_entry(k);
        end
        return t;
    endfunction

endpackage

// File: rtl/polar_point_engine_trig_rom.sv
// ---------------------------------------------------------------------------
// trig_quarter_rom
// Quarter-wave sine table, Q+1 entries of ROM_W bits, one-cycle synchronous
// read. Contents are generated at elaboration from polar_pkg::sine_entry.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset (clears the read register)
//   addr_s  : table index 0..Q
//   data_r  : registered table value, valid the cycle after addr_s
// ---------------------------------------------------------------------------
module trig_quarter_rom
    import polar_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ROM_A_W-1:0] addr_s,
    output logic [ROM_W-1:0]   data_r
);

    localparam logic [(Q+1)*ROM_W-1:0] SINE_TABLE = build_sine_table();

    // Registered table read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else begin
            data_r <= SINE_TABLE[addr_s*ROM_W +: ROM_W];
        end
    end

endmodule

// File: rtl/polar_point_engine.sv
// ---------------------------------------------------------------------------
// polar_point_engine
// Time-multiplexed polar-to-cartesian engine. On a start pulse in IDLE all
// inputs are snapshotted, then each channel c gets
//   X = cx + r*cos(a+phase_off), Y = cy + r*sin(a+phase_off)
// using one shared quarter-wave ROM and one shared multiplier, four cycles
// per channel. Results are clamped to the screen and held until rewritten.
//   CLK, Reset        : clock, asynchronous active-high reset
//   start             : run request, only honoured in IDLE
//   centerX/centerY   : per-channel centre, channel c at [c*COORD_W +: COORD_W]
//   radius            : per-channel radius
//   angle             : per-channel angle (clockwise on screen)
//   mode              : per-channel 2 bits, bit0 negates cos, bit1 negates sin
//   phase_off         : global angle offset, modulo a full circle
//   busy              : high while a run is in progress
//   done              : one-cycle pulse with the last channel's write
//   RotX/RotY         : registered results per channel
//   clip              : per-channel flag, X or Y was clamped on the last run
// ---------------------------------------------------------------------------
module polar_point_engine
    import polar_pkg::*;
#(
    parameter int NUM_CH  = 32'sd4,
    parameter int COORD_W = 32'sd10
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      start,
    input  logic [NUM_CH*COORD_W-1:0] centerX,
    input  logic [NUM_CH*COORD_W-1:0] centerY,
    input  logic [NUM_CH*COORD_W-1:0] radius,
    input  logic [NUM_CH*ANG_W-1:0]   angle,
    input  logic [NUM_CH*2-1:0]       mode,
    input  logic [ANG_W-1:0]          phase_off,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH*COORD_W-1:0] RotX,
    output logic [NUM_CH*COORD_W-1:0] RotY,
    output logic [NUM_CH-1:0]         clip
);

    localparam int CH_W   = (NUM_CH > 32'sd1) ? $clog2(NUM_CH) : 32'sd1;
    localparam int MODE_W = 32'sd2;
    localparam int PROD_W = COORD_W + ROM_W;
    // Magnitude after dropping FRAC_W bits; one bit wider than a coordinate
    // because the full-scale table entry is 2^FRAC_W.
    localparam int MAG_W  = PROD_W - FRAC_W;
    // Signed sum range: -(2^COORD_W-1) .. 2*(2^COORD_W-1).
    localparam int SUM_W  = COORD_W + 32'sd2;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 32'sd1);

    // Sequencing
    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [CH_W-1:0]           chan_r;

    // Run snapshot
    logic [NUM_CH*COORD_W-1:0] snap_cx_r;
    logic [NUM_CH*COORD_W-1:0] snap_cy_r;
    logic [NUM_CH*COORD_W-1:0] snap_rad_r;
    logic [NUM_CH*ANG_W-1:0]   snap_ang_r;
    logic [NUM_CH*MODE_W-1:0]  snap_mode_r;
    logic [ANG_W-1:0]          snap_phase_r;

    // Datapath
    logic [COORD_W-1:0]        cur_cx_s;
    logic [COORD_W-1:0]        cur_cy_s;
    logic [COORD_W-1:0]        cur_rad_s;
    logic [ANG_W-1:0]          cur_ang_s;
    logic [MODE_W-1:0]         cur_mode_s;
    logic [ANG_W-1:0]          eff_ang_s;
    logic [ANG_W-1:0]          cos_ang_s;
    fold_t                     sin_fold_s;
    fold_t                     cos_fold_s;
    logic [ROM_A_W-1:0]        rom_addr_s;
    logic [ROM_W-1:0]          rom_data_s;
    logic [PROD_W-1:0]         product_s;
    logic [MAG_W-1:0]          mag_s;
    logic [MAG_W-1:0]          mag_x_r;
    logic [MAG_W-1:0]          mag_y_r;
    logic                      neg_x_s;
    logic                      neg_y_s;
    logic signed [SUM_W-1:0]   off_x_s;
    logic signed [SUM_W-1:0]   off_y_s;
    logic signed [SUM_W-1:0]   sum_x_s;
    logic signed [SUM_W-1:0]   sum_y_s;
    logic [COORD_W:0]          clamp_x_s;
    logic [COORD_W:0]          clamp_y_s;

    // Outputs
    logic                      busy_r;
    logic                      done_r;
    logic [NUM_CH*COORD_W-1:0] rot_x_r;
    logic [NUM_CH*COORD_W-1:0] rot_y_r;
    logic [NUM_CH-1:0]         clip_r;

    // Saturate a signed sum to 0..2^COORD_W-1; MSB of the result is the clip flag.
    function automatic logic [COORD_W:0] clamp_coord(input logic signed [SUM_W-1:0] v);
        logic [COORD_W:0] res;
        if (v[SUM_W-1]) begin
            res = {1'b1, {COORD_W{1'b0}}};
        end else if (v[COORD_W]) begin
            res = {1'b1, {COORD_W{1'b1}}};
        end else begin
            res = {1'b0, v[COORD_W-1:0]};
        end
        return res;
    endfunction

    trig_quarter_rom u_rom (
        .clk    (CLK),
        .rst    (Reset),
        .addr_s (rom_addr_s),
        .data_r (rom_data_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = COS_ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COS_ADDR: state_nxt_s = SIN_ADDR;
            SIN_ADDR: state_nxt_s = SIN_CAP;
            SIN_CAP:  state_nxt_s = CALC;
            CALC: begin
                if (chan_r == LAST_CH) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = COS_ADDR;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-channel operand select, angle fold, shared multiply and clamp.
    always_comb begin
        cur_cx_s   = snap_cx_r[chan_r*COORD_W +: COORD_W];
        cur_cy_s   = snap_cy_r[chan_r*COORD_W +: COORD_W];
        cur_rad_s  = snap_rad_r[chan_r*COORD_W +: COORD_W];
        cur_ang_s  = snap_ang_r[chan_r*ANG_W +: ANG_W];
        cur_mode_s = snap_mode_r[chan_r*MODE_W +: MODE_W];

        eff_ang_s  = cur_ang_s + snap_phase_r;
        cos_ang_s  = eff_ang_s + ANG_W'(Q);
        sin_fold_s = fold_quadrant(eff_ang_s);
        cos_fold_s = fold_quadrant(cos_ang_s);

        case (state_r)
            COS_ADDR: rom_addr_s = cos_fold_s.addr;
            SIN_ADDR: rom_addr_s = sin_fold_s.addr;
            default:  rom_addr_s = sin_fold_s.addr;
        endcase

        // The ROM output carries cos data in SIN_ADDR and sin data in SIN_CAP,
        // so one multiplier serves both axes on consecutive cycles.
        product_s = {{ROM_W{1'b0}}, cur_rad_s} * {{COORD_W{1'b0}}, rom_data_s};
        mag_s     = product_s[PROD_W-1:FRAC_W];

        neg_x_s   = cos_fold_s.neg ^ cur_mode_s[0];
        neg_y_s   = sin_fold_s.neg ^ cur_mode_s[1];
        off_x_s   = neg_x_s ? -$signed({1'b0, mag_x_r}) : $signed({1'b0, mag_x_r});
        off_y_s   = neg_y_s ? -$signed({1'b0, mag_y_r}) : $signed({1'b0, mag_y_r});
        sum_x_s   = $signed({2'b00, cur_cx_s}) + off_x_s;
        sum_y_s   = $signed({2'b00, cur_cy_s}) + off_y_s;
        clamp_x_s = clamp_coord(sum_x_s);
        clamp_y_s = clamp_coord(sum_y_s);
    end

    // Snapshot, channel counter, magnitude capture and result registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            chan_r       <= '0;
            snap_cx_r    <= '0;
            snap_cy_r    <= '0;
            snap_rad_r   <= '0;
            snap_ang_r   <= '0;
            snap_mode_r  <= '0;
            snap_phase_r <= '0;
            mag_x_r      <= '0;
            mag_y_r      <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rot_x_r      <= '0;
            rot_y_r      <= '0;
            clip_r       <= '0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        snap_cx_r    <= centerX;
                        snap_cy_r    <= centerY;
                        snap_rad_r   <= radius;
                        snap_ang_r   <= angle;
                        snap_mode_r  <= mode;
                        snap_phase_r <= phase_off;
                        chan_r       <= '0;
                    end else begin
                        chan_r       <= chan_r;
                    end
                end
                SIN_ADDR: mag_x_r <= mag_s;
                SIN_CAP:  mag_y_r <= mag_s;
                CALC: begin
                    rot_x_r[chan_r*COORD_W +: COORD_W] <= clamp_x_s[COORD_W-1:0];
                    rot_y_r[chan_r*COORD_W +: COORD_W] <= clamp_y_s[COORD_W-1:0];
                    clip_r[chan_r] <= clamp_x_s[COORD_W] | clamp_y_s[COORD_W];
                    if (chan_r == LAST_CH) begin
                        done_r <= 1'b1;
                        chan_r <= '0;
                    end else begin
                        chan_r <= chan_r + CH_W'(1'b1);
                    end
                end
                default: begin
                    chan_r <= chan_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign RotX = rot_x_r;
    assign RotY = rot_y_r;
    assign clip = clip_r;

endmodule

// File: tb/tb_polar_point_engine.sv
module tb_polar_point_engine;

    localparam int NUM_CH  = 4;
    localparam int COORD_W = 10;
    localparam int ANG_W   = 9;
    localparam int NVEC    = 21;

    logic                      CLK = 1'b0;
    logic                      Reset;
    logic                      start;
    logic [NUM_CH*COORD_W-1:0] centerX;
    logic [NUM_CH*COORD_W-1:0] centerY;
    logic [NUM_CH*COORD_W-1:0] radius;
    logic [NUM_CH*ANG_W-1:0]   angle;
    logic [NUM_CH*2-1:0]       mode;
    logic [ANG_W-1:0]          phase_off;
    logic                      busy;
    logic                      done;
    logic [NUM_CH*COORD_W-1:0] RotX;
    logic [NUM_CH*COORD_W-1:0] RotY;
    logic [NUM_CH-1:0]         clip;

    polar_point_engine #(.NUM_CH(NUM_CH), .COORD_W(COORD_W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .centerX   (centerX),
        .centerY   (centerY),
        .radius    (radius),
        .angle     (angle),
        .mode      (mode),
        .phase_off (phase_off),
        .busy      (busy),
        .done      (done),
        .RotX      (RotX),
        .RotY      (RotY),
        .clip      (clip)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cx, cy, r, a, ph, md;
        int ex, ey, ec;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_chk  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input int cx, input int cy, input int r, input int a,
                                input int ph, input int md,
                                input int ex, input int ey, input int ec);
        vec_t v;
        v.cx = cx; v.cy = cy; v.r = r; v.a = a; v.ph = ph; v.md = md;
        v.ex = ex; v.ey = ey; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Vector goes on channel 'slot'; other channels get radius 0, so their
    // result must equal their own centre.
    task automatic load_vec(input vec_t v, input int slot);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c == slot) begin
                centerX[c*COORD_W +: COORD_W] = v.cx[COORD_W-1:0];
                centerY[c*COORD_W +: COORD_W] = v.cy[COORD_W-1:0];
                radius[c*COORD_W +: COORD_W]  = v.r[COORD_W-1:0];
                angle[c*ANG_W +: ANG_W]       = v.a[ANG_W-1:0];
                mode[c*2 +: 2]                = v.md[1:0];
            end else begin
                centerX[c*COORD_W +: COORD_W] = COORD_W'(c*7 + 1);
                centerY[c*COORD_W +: COORD_W] = COORD_W'(c*3 + 2);
                radius[c*COORD_W +: COORD_W]  = '0;
                angle[c*ANG_W +: ANG_W]       = ANG_W'(c*50 + 3);
                mode[c*2 +: 2]                = 2'(c);
            end
        end
        phase_off = v.ph[ANG_W-1:0];
    endtask

    task automatic check_outputs(input vec_t v, input int slot, input string tag);
        int ex, ey, ec;
        for (int c = 0; c < NUM_CH; c++) begin
            ex = (c == slot) ? v.ex : c*7 + 1;
            ey = (c == slot) ? v.ey : c*3 + 2;
            ec = (c == slot) ? v.ec : 0;
            check($sformatf("%s ch%0d X", tag, c), int'(RotX[c*COORD_W +: COORD_W]), ex);
            check($sformatf("%s ch%0d Y", tag, c), int'(RotY[c*COORD_W +: COORD_W]), ey);
            check($sformatf("%s ch%0d clip", tag, c), int'(clip[c]), ec);
        end
    endtask

    // Pulse start for one edge (t0), then watch 24 edges for done pulses.
    task automatic run_once(output int cyc, output int cnt);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc = -1;
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                cnt++;
                if (cyc < 0) cyc = k;
            end
        end
    endtask

    initial begin
        int cyc, cnt, first, second, busy16, busy17;

        Reset     = 1'b1;
        start     = 1'b0;
        centerX   = '0;
        centerY   = '0;
        radius    = '0;
        angle     = '0;
        mode      = '0;
        phase_off = '0;

        //             cx    cy    r     a    ph  md   X     Y    clip
        vecs[0]  = mk(320,  240,  100,    0,   0, 0,  420,  240, 0);
        vecs[1]  = mk(320,  240,  100,  128,   0, 0,  320,  340, 0);
        vecs[2]  = mk(320,  240,  100,  256,   0, 0,  220,  240, 0);
        vecs[3]  = mk(320,  240,  100,  384,   0, 0,  320,  140, 0);
        vecs[4]  = mk(320,  240,  100,   64,   0, 0,  390,  310, 0);
        vecs[5]  = mk(320,  240,  100,  192,   0, 0,  250,  310, 0);
        vecs[6]  = mk( 10,   10,  100,  256,   0, 0,    0,   10, 1);
        vecs[7]  = mk(1000, 240,  100,    0,   0, 0, 1023,  240, 1);
        vecs[8]  = mk(320,  240,  100,  500,  20, 0,  419,  249, 0);
        vecs[9]  = mk(320,  240,  100,    8,   0, 0,  419,  249, 0);
        vecs[10] = mk(320,  240,  100,    0,   0, 3,  220,  240, 0);
        vecs[11] = mk(320,  240,  100,    0,   0, 1,  220,  240, 0);
        vecs[12] = mk(320,  240,  100,  128,   0, 2,  320,  140, 0);
        vecs[13] = mk(500,  600,    0,   77,   0, 0,  500,  600, 0);
        vecs[14] = mk(320,   50,  100,  384,   0, 0,  320,    0, 1);
        vecs[15] = mk(320, 1000,  100,  128,   0, 0,  320, 1023, 1);
        vecs[16] = mk(512,  512, 1023,   64,   0, 0, 1023, 1023, 1);
        vecs[17] = mk(320,  240,  100,    0, 256, 0,  220,  240, 0);
        vecs[18] = mk(320,  240,  100,   64,   0, 3,  250,  170, 0);
        vecs[19] = mk(320,  240,  100,  264,   0, 0,  221,  231, 0);
        vecs[20] = mk(320,  240,  100,  392,   0, 0,  329,  141, 0);

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset RotX ones", $countones(RotX), 0);
        check("reset RotY ones", $countones(RotY), 0);
        check("reset clip ones", $countones(clip), 0);
        @(negedge CLK);
        Reset = 1'b0;

        // Table-driven vectors, rotating the target channel
        for (int vi = 0; vi < NVEC; vi++) begin
            load_vec(vecs[vi], vi % NUM_CH);
            run_once(cyc, cnt);
            check($sformatf("vec%0d done cycle", vi), cyc, 16);
            check($sformatf("vec%0d done count", vi), cnt, 1);
            check_outputs(vecs[vi], vi % NUM_CH, $sformatf("vec%0d", vi));
        end

        // Snapshot isolation and start-while-busy
        load_vec(vecs[0], 0);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        cyc = -1;
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge CLK);
            if (k == 1) centerX[0 +: COORD_W] = 10'd100;
            start = (k == 5);
            @(posedge CLK);
            #1;
            if (done) begin
                cnt++;
                if (cyc < 0) cyc = k;
            end
        end
        check("busy-start done cycle", cyc, 16);
        check("busy-start done count", cnt, 1);
        check("snapshot ch0 X", int'(RotX[0 +: COORD_W]), 420);

        // start held high re-arms on the cycle after done
        load_vec(vecs[1], 1);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        first  = -1;
        second = -1;
        cnt    = 0;
        busy16 = -1;
        busy17 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 20) start = 1'b0;
            @(posedge CLK);
            #1;
            if (k == 16) busy16 = int'(busy);
            if (k == 17) busy17 = int'(busy);
            if (done) begin
                cnt++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check("rearm first done", first, 16);
        check("rearm second done", second, 33);
        check("rearm done count", cnt, 2);
        check("rearm busy after done", busy16, 0);
        check("rearm busy restarted", busy17, 1);
        check_outputs(vecs[1], 1, "rearm");

        // Reset in the middle of a run
        load_vec(vecs[2], 2);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (6) @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset RotX ones", $countones(RotX), 0);
        check("midreset RotY ones", $countones(RotY), 0);
        check("midreset clip ones", $countones(clip), 0);
        @(negedge CLK);
        Reset = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge CLK);
            #1;
            if (done) cnt++;
        end
        check("midreset no done", cnt, 0);
        check("midreset idle busy", int'(busy), 0);

        load_vec(vecs[2], 2);
        run_once(cyc, cnt);
        check("post-reset done cycle", cyc, 16);
        check("post-reset done count", cnt, 1);
        check_outputs(vecs[2], 2, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
